// File: rtl/cla_nibble_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_seq_if
//  Description : Request/response bundle for the nibble-serial CLA adder.
//                The requester drives start and the operands. The adder
//                returns the handshake status, the result and its flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface cla_nibble_seq_if #(
   parameter int WIDTH = 16
);
   // Request side
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;

   // Response side
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   // Requesting datapath
   modport master (
      output start, a, b, cin,
      input  ready, busy, done, sum, cout, ovf, zero
   );

   // Adder controller
   modport slave (
      input  start, a, b, cin,
      output ready, busy, done, sum, cout, ovf, zero
   );
endinterface
`default_nettype wire

// File: rtl/cla_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_seq
//  Description : Multi-precision adder that time-multiplexes one 4-bit
//                carry-lookahead slice over a WIDTH-bit operand pair, one
//                nibble per clock, least significant nibble first. The slice
//                carry-out is registered and feeds the next nibble.
//                WIDTH must be a multiple of 4 and at least 8.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_nibble_seq #(
   parameter int WIDTH = 16
) (
   input  wire logic       clk,
   input  wire logic       rst,
   cla_nibble_seq_if.slave bus
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   // Captured operands and working registers
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [IDXW-1:0]  r_idx;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   // Decoded handshake
   logic             w_ready;
   logic             w_busy;
   logic             w_done;

   // CLA slice signals
   logic [3:0]       w_x;
   logic [3:0]       w_y;
   logic [3:0]       w_g;
   logic [3:0]       w_p;
   logic             w_c1;
   logic             w_c2;
   logic             w_c3;
   logic             w_c4;
   logic [3:0]       w_s;
   logic             w_last;
   logic             w_zero_all;

   // ------------------------------------------------------------------------
   // Nibble selection: the index scales to a bit offset by appending 2'b00.
   // ------------------------------------------------------------------------
   assign w_x = r_a[{r_idx, 2'b00} +: 4];
   assign w_y = r_b[{r_idx, 2'b00} +: 4];

   // ------------------------------------------------------------------------
   // 4-bit carry-lookahead slice. Every carry is a flat sum of products of
   // generate/propagate terms and the incoming carry, so no carry ripples
   // inside the nibble. This is the only adder in the block.
   // ------------------------------------------------------------------------
   assign w_g  = w_x & w_y;
   assign w_p  = w_x ^ w_y;

   assign w_c1 = w_g[0]
               | (w_p[0] & r_carry);
   assign w_c2 = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & r_carry);
   assign w_c3 = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
   assign w_c4 = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);

   assign w_s  = w_p ^ {w_c3, w_c2, w_c1, r_carry};

   assign w_last = (r_idx == LAST_IDX);

   // The last nibble is the top one, so every lower nibble already holds
   // its final value when the zero flag is evaluated.
   assign w_zero_all = (w_s == 4'd0) && (r_sum[WIDTH-5:0] == '0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and handshake decode straight from the state
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.start) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Operand capture, nibble-serial sum accumulation and result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_carry <= bus.cin;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_zero  <= 1'b0;
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 2'b00} +: 4] <= w_s;
               r_carry                    <= w_c4;
               if (w_last) begin
                  // Carry into the MSB is the slice's internal bit-3 carry.
                  r_idx  <= '0;
                  r_cout <= w_c4;
                  r_ovf  <= w_c3 ^ w_c4;
                  r_zero <= w_zero_all;
               end else begin
                  r_idx  <= r_idx + IDXW'(1);
               end
            end
            default: begin
               // DONE: results simply hold.
            end
         endcase
      end
   end

   assign bus.ready = w_ready;
   assign bus.busy  = w_busy;
   assign bus.done  = w_done;
   assign bus.sum   = r_sum;
   assign bus.cout  = r_cout;
   assign bus.ovf   = r_ovf;
   assign bus.zero  = r_zero;

endmodule
`default_nettype wire
